decoder_scan_sequencer: RTL and testbench
=========================================

Name: decoder_scan_sequencer

Overview:
- Upstream driver for the parameterised one-hot decoder.
- Steps the decoder's select input `w` through every index 0..2**N-1 and holds each index for a programmable dwell time.
- Drives the decoder's enable per slot, so masked outputs are never asserted.
- Typical uses: display digit scanning, keypad row strobing, chip-select sequencing. Supports one-shot frames and continuous scanning.

Parameters:
- N, 3, decoder select width; the frame has 2**N slots.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- stop  input  1  abort scanning; sampled in SCAN.
- continuous  input  1  1 = wrap after the last slot; 0 = one frame, then done. Latched at start.
- dwell  input  DWELL_W  a slot with its mask bit set lasts dwell+1 cycles. Latched at start.
- mask  input  [0:2**N-1]  mask[i]=1 enables slot i. Same ascending index order as the decoder output. Latched at start.
- addr  output  N  select index, fed to the decoder `w`.
- en  output  1  enable, fed to the decoder `en`.
- busy  output  1  high while in SCAN.
- step  output  1  one-cycle pulse on the last cycle of each slot.
- done  output  1  one-cycle pulse when a one-shot frame completes normally.

Behaviour:
- Reset: rst=1 immediately forces the following, asynchronously and regardless of clk:
  - state=IDLE, addr=0, en=0, busy=0, step=0, done=0;
  - internal dwell counter=0, mask_q=0, dwell_q=0, cont_q=0.
- All outputs come from registers or from a decode of registered state only. There is no combinational path from any input to any output.
- States: IDLE, SCAN. DONE is not a state; done is a registered pulse.
- IDLE:
  - addr=0, en=0, busy=0.
  - If start=1 and stop=0 at an edge: latch mask_q, dwell_q, cont_q; clear the counter; enter SCAN with addr=0.
  - start=1 together with stop=1 in IDLE: stay in IDLE.
- SCAN:
  - busy=1; en = mask_q[addr].
  - Enabled slot (mask_q[addr]=1): counter runs 0..dwell_q; the slot ends in the cycle where counter==dwell_q. Length = dwell_q+1 cycles (dwell=0 gives 1 cycle).
  - Masked slot (mask_q[addr]=0): the slot lasts exactly 1 cycle with en=0.
  - step=1 in the final cycle of every slot, masked or not.
- Slot end with addr < 2**N-1: addr increments by 1 at the next edge and the counter clears.
- Slot end with addr = 2**N-1:
  - cont_q=1: addr wraps to 0, stay in SCAN. No done pulse; no idle gap between frames.
  - cont_q=0: go to IDLE. At that edge busy goes 0, done goes 1 for exactly one cycle, and addr=0.
- stop=1 in SCAN:
  - Next edge: IDLE, addr=0, en=0, busy=0, counter cleared, no done pulse.
  - stop takes priority over a simultaneous slot end or wrap.
  - step may still be 1 in the cycle stop is sampled, if that cycle is a slot end.
- start while busy is ignored. Changes to mask, dwell or continuous during SCAN have no effect until the next start.
- All-zero mask: en is never 1. The frame lasts 2**N cycles and step is high every cycle.
- Frame length (one-shot) = sum over i of (mask_q[i] ? dwell_q+1 : 1) cycles. busy is high for exactly that many cycles.
- Reset mid-SCAN: immediately returns to IDLE values. No done pulse; no step pulse.
- Counter width is DWELL_W. Maximum dwell = 2**DWELL_W-1, giving 2**DWELL_W cycles per slot, with no overflow.

Test Plan:
- Reset/idle: rst pulsed asynchronously between clock edges -> outputs clear immediately to addr=0, en=0, busy=0, step=0, done=0, and stay there for 20 cycles with start=0.
- One-shot, N=2, dwell=2, mask=1011 (mask[0]=1, mask[1]=0, mask[2]=1, mask[3]=1), continuous=0, one-cycle start:
  - addr sequence 0,0,0,1,2,2,2,3,3,3; en=1 except the addr=1 cycle; busy high for 10 cycles.
  - step high on cycles 3, 4, 7 and 10.
  - done high for one cycle as busy falls; addr=0 after.
- Continuous, N=2, dwell=0, mask=1111: addr runs 0,1,2,3,0,1,... every cycle with en=1 and step=1 on every cycle. After 12 cycles, stop=1 -> next edge busy=0, en=0, addr=0, done never pulses.
- Stop priority: one-shot frame, stop asserted in the final cycle (addr=3, slot end) -> IDLE with done=0. Also start=1 with stop=1 in IDLE -> busy stays 0.
- Latching/ignore: during SCAN change mask to 0000 and dwell to 5 and pulse start -> current frame timing unchanged. The next start uses the new values: mask 0000 gives 4 cycles, en never 1, done pulses.
- Boundaries: all-zero mask gives a frame of exactly 2**N cycles. DWELL_W=8 with dwell=255 gives a 256-cycle slot, no wrap of the counter, and addr increments exactly once.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer for a one-hot decoder: steps the select index through every slot,
// holding enabled slots for dwell+1 cycles and masked slots for one cycle.
module decoder_scan_sequencer #(
    parameter int unsigned N       = 3,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_continuous,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [0:2**N-1]    i_mask,
    output logic [N-1:0]       o_addr,
    output logic               o_en,
    output logic               o_busy,
    output logic               o_step,
    output logic               o_done
);

    typedef enum logic {
        StIdle,
        StScan
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_addr;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic [0:2**N-1]    r_mask;
    logic               r_cont;
    logic               r_done;

    state_t             w_state_nxt;
    logic [N-1:0]       w_addr_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [0:2**N-1]    w_mask_nxt;
    logic               w_cont_nxt;
    logic               w_done_nxt;
    logic               w_scan;
    logic               w_slot_en;
    logic               w_slot_end;
    logic               w_last_slot;

    assign w_scan      = (r_state == StScan);
    assign w_slot_en   = r_mask[r_addr];
    // Masked slots always last a single cycle, regardless of the dwell count.
    assign w_slot_end  = w_scan && (!w_slot_en || (r_cnt == r_dwell));
    assign w_last_slot = &r_addr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_mask  <= '0;
            r_cont  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dwell <= w_dwell_nxt;
            r_mask  <= w_mask_nxt;
            r_cont  <= w_cont_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_dwell_nxt = r_dwell;
        w_mask_nxt  = r_mask;
        w_cont_nxt  = r_cont;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_addr_nxt = '0;
                w_cnt_nxt  = '0;
                if (i_start && !i_stop) begin
                    w_state_nxt = StScan;
                    w_mask_nxt  = i_mask;
                    w_dwell_nxt = i_dwell;
                    w_cont_nxt  = i_continuous;
                end
            end
            StScan: begin
                // Abort wins over any slot end or wrap in the same cycle.
                if (i_stop) begin
                    w_state_nxt = StIdle;
                    w_addr_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else if (w_slot_end) begin
                    w_cnt_nxt = '0;
                    if (!w_last_slot) begin
                        w_addr_nxt = r_addr + 1'b1;
                    end else begin
                        w_addr_nxt = '0;
                        if (!r_cont) begin
                            w_state_nxt = StIdle;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_addr_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_addr = r_addr;
    assign o_busy = w_scan;
    assign o_en   = w_scan && w_slot_en;
    assign o_step = w_slot_end;
    assign o_done = r_done;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench: a slot-queue reference model predicts every output on every cycle,
// with directed frames pinned by literal expectations plus a randomized run.
module tb_decoder_scan_sequencer;

    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int SLOTS = 2 ** N;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                stop;
    logic                cont;
    logic [DW-1:0]       dwell;
    logic [0:SLOTS-1]    mask;
    logic [N-1:0]        addr;
    logic                en;
    logic                busy;
    logic                step;
    logic                done;

    decoder_scan_sequencer #(
        .N       (N),
        .DWELL_W (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_continuous (cont),
        .i_dwell      (dwell),
        .i_mask       (mask),
        .o_addr       (addr),
        .o_en         (en),
        .o_busy       (busy),
        .o_step       (step),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit en;
        bit step;
    } cyc_t;

    // Each queue entry is one future busy cycle; the head is the current cycle.
    cyc_t             m_q[$];
    bit               m_done;
    bit               m_cont;
    int               m_dwell;
    bit [0:SLOTS-1]   m_mask;

    int n_checks = 0;
    int n_err    = 0;
    int s_addr, s_en, s_busy, s_step, s_done;
    int rec_addr[0:511];
    int rec_step[0:511];

    function automatic void chk(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_done  = 1'b0;
        m_cont  = 1'b0;
        m_dwell = 0;
        m_mask  = '0;
    endfunction

    function automatic void model_fill();
        for (int i = 0; i < SLOTS; i++) begin
            int len;
            len = m_mask[i] ? m_dwell + 1 : 1;
            for (int k = 0; k < len; k++) m_q.push_back('{i, m_mask[i], k == len - 1});
        end
    endfunction

    function automatic void model_edge();
        m_done = 1'b0;
        if (rst) begin
            model_clear();
        end else if (m_q.size() > 0) begin
            if (stop) begin
                m_q.delete();
            end else begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    if (m_cont) model_fill();
                    else m_done = 1'b1;
                end
            end
        end else if (start && !stop) begin
            m_mask  = mask;
            m_dwell = int'(dwell);
            m_cont  = cont;
            model_fill();
        end
    endfunction

    task automatic check_outputs();
        int eb, ea, ee, es;
        eb = (m_q.size() > 0) ? 1 : 0;
        ea = 0;
        ee = 0;
        es = 0;
        if (eb != 0) begin
            ea = m_q[0].addr;
            ee = int'(m_q[0].en);
            es = int'(m_q[0].step);
        end
        chk("busy", int'(busy), eb);
        chk("addr", int'(addr), ea);
        chk("en", int'(en), ee);
        chk("step", int'(step), es);
        chk("done", int'(done), int'(m_done));
        s_addr = int'(addr);
        s_en   = int'(en);
        s_busy = int'(busy);
        s_step = int'(step);
        s_done = int'(done);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        check_outputs();
    endtask

    // Reset asserted between clock edges must clear the outputs before the next edge.
    task automatic async_reset();
        @(posedge clk);
        model_edge();
        #3;
        rst = 1'b1;
        model_clear();
        #1;
        check_outputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_frame(input int limit, output int nbusy, output int ndone,
                             output int nen);
        nbusy = 0;
        ndone = 0;
        nen   = 0;
        for (int k = 0; k < limit && s_busy != 0; k++) begin
            rec_addr[nbusy] = s_addr;
            rec_step[nbusy] = s_step;
            nbusy++;
            nen += s_en;
            tick();
            ndone += s_done;
        end
        chk("frame_terminates", s_busy, 0);
    endtask

    task automatic begin_frame(input logic [0:SLOTS-1] m, input int d, input logic c);
        mask  = m;
        dwell = DW'(d);
        cont  = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int nb, nd, ne, cnt0;
        int exp_a[10];
        int exp_s[10];
        exp_a = '{0, 0, 0, 1, 2, 2, 2, 3, 3, 3};
        exp_s = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 1};

        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cont  = 1'b0;
        dwell = '0;
        mask  = '0;
        model_clear();
        #3;
        rst = 1'b1;
        #1;
        check_outputs();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        // One-shot, dwell=2, mask 1011
        begin_frame(4'b1011, 2, 1'b0);
        run_frame(50, nb, nd, ne);
        chk("oneshot_len", nb, 10);
        chk("oneshot_done", nd, 1);
        chk("oneshot_en_cycles", ne, 9);
        for (int i = 0; i < 10; i++) begin
            chk("oneshot_addr_seq", rec_addr[i], exp_a[i]);
            chk("oneshot_step_seq", rec_step[i], exp_s[i]);
        end
        chk("oneshot_addr_after", s_addr, 0);
        tick();

        // Continuous, dwell=0, stop after 12 cycles
        begin_frame(4'b1111, 0, 1'b1);
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            chk("cont_addr", s_addr, c % 4);
            chk("cont_step", s_step, 1);
            tick();
            nd += s_done;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        nd += s_done;
        chk("cont_stop_busy", s_busy, 0);
        chk("cont_stop_addr", s_addr, 0);
        chk("cont_no_done", nd, 0);
        tick();

        // Stop on the final slot end of a one-shot frame
        begin_frame(4'b1111, 1, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("stopprio_addr", s_addr, 3);
        chk("stopprio_step", s_step, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stopprio_busy", s_busy, 0);
        chk("stopprio_done", s_done, 0);
        tick();
        chk("stopprio_done_late", s_done, 0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", s_busy, 0);
        tick();

        // Inputs changed mid-frame are ignored until the next start
        begin_frame(4'b1011, 2, 1'b0);
        tick();
        tick();
        mask  = 4'b0000;
        dwell = DW'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(50, nb, nd, ne);
        chk("latched_len", nb + 3, 10);
        begin_frame(4'b0000, 5, 1'b0);
        run_frame(50, nb, nd, ne);
        chk("zero_mask_len", nb, SLOTS);
        chk("zero_mask_en", ne, 0);
        chk("zero_mask_done", nd, 1);
        tick();

        // Maximum dwell on slot 0
        begin_frame(4'b1000, 255, 1'b0);
        run_frame(400, nb, nd, ne);
        chk("maxdwell_len", nb, 259);
        cnt0 = 0;
        for (int i = 0; i < 259; i++) if (rec_addr[i] == 0) cnt0++;
        chk("maxdwell_slot0_cycles", cnt0, 256);
        chk("maxdwell_addr_inc", rec_addr[256], 1);
        chk("maxdwell_step_end", rec_step[255], 1);
        chk("maxdwell_step_mid", rec_step[254], 0);
        tick();

        // Reset mid-scan
        begin_frame(4'b1111, 3, 1'b0);
        tick();
        tick();
        async_reset();
        chk("midscan_reset_busy", s_busy, 0);
        chk("midscan_reset_done", s_done, 0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 6) == 0;
            stop  = ($urandom % 30) == 0;
            cont  = 1'($urandom % 2);
            mask  = 4'($urandom);
            dwell = (($urandom % 10) == 0) ? DW'($urandom % 20) : DW'($urandom % 4);
            if (($urandom % 500) == 0) async_reset();
            else tick();
        end
        start = 1'b0;
        stop  = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
